// File: rtl/reg_file_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_pkg
// Shared definitions for the register-file writeback arbiter.
//   WIDTH      : data width of one architectural register
//   SIZE       : register address width
//   NUM_REGS   : number of architectural registers (2**SIZE)
//   wb_entry_t : one pending writeback {rd, data}; used by the port-B FIFO
//                and by the registered output stage of the arbiter
// -----------------------------------------------------------------------------
package reg_file_pkg;

    localparam int WIDTH    = 32;
    localparam int SIZE     = 5;
    localparam int NUM_REGS = 2 ** SIZE;

    typedef struct packed {
        logic [SIZE-1:0]  rd;
        logic [WIDTH-1:0] data;
    } wb_entry_t;

endpackage : reg_file_pkg

// File: rtl/wb_fifo.sv
// -----------------------------------------------------------------------------
// wb_fifo
// Synchronous FIFO of wb_entry_t used to buffer multi-cycle unit results until
// a free register-file write slot appears.
//
// Ports:
//   clk         in   clock, rising edge
//   reset       in   asynchronous active-high reset, empties the FIFO
//   push_i      in   write push_data_i at the tail (ignored when full)
//   push_data_i in   entry to enqueue
//   pop_i       in   drop the head entry (ignored when empty)
//   head_o      out  current head entry, valid whenever empty_o is 0
//   full_o      out  DEPTH entries stored
//   empty_o     out  no entries stored
//
// The head is read combinationally so that an entry pushed at edge n can be
// popped in the very next cycle.
// -----------------------------------------------------------------------------
module wb_fifo
    import reg_file_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  wb_entry_t push_data_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    wb_entry_t mem [DEPTH];

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // when the index bits are equal.
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;

    logic do_push;
    logic do_pop;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign head_o = mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define which slots are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule : wb_fifo

// File: rtl/reg_file_wb_arbiter.sv
// -----------------------------------------------------------------------------
// reg_file_wb_arbiter
// Shares the register file's single write port between the main pipeline
// writeback (port A, never stalls, highest priority) and the multi-cycle unit
// (port B, valid/ready, buffered in wb_fifo). Also exports a pending-write
// scoreboard and a starvation stall request for the hazard logic.
//
// Ports:
//   clk              in   clock, rising edge
//   reset            in   asynchronous active-high reset
//   a_valid_i        in   pipeline writeback valid
//   a_register_i     in   pipeline destination register
//   a_data_i         in   pipeline write data
//   b_valid_i        in   multi-cycle result valid
//   b_ready_o        out  FIFO can accept a port-B result (state only)
//   b_register_i     in   multi-cycle destination register
//   b_data_i         in   multi-cycle result data
//   reg_write_o      out  register file write enable
//   write_register_o out  register file write address
//   write_data_o     out  register file write data
//   busy_mask_o      out  bit r set while a write to r waits in the FIFO
//   stall_req_o      out  ask the pipeline for a bubble (port B starving)
//   error_o          out  sticky protocol violation flag
//
// WIDTH and SIZE must match reg_file_pkg, which sizes the shared entry type.
// -----------------------------------------------------------------------------
module reg_file_wb_arbiter
    import reg_file_pkg::*;
#(
    parameter int WIDTH     = reg_file_pkg::WIDTH,
    parameter int SIZE      = reg_file_pkg::SIZE,
    parameter int DEPTH     = 4,
    parameter int MAX_STALL = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_valid_i,
    input  logic [SIZE-1:0]       a_register_i,
    input  logic [WIDTH-1:0]      a_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    input  logic [SIZE-1:0]       b_register_i,
    input  logic [WIDTH-1:0]      b_data_i,
    output logic                  reg_write_o,
    output logic [SIZE-1:0]       write_register_o,
    output logic [WIDTH-1:0]      write_data_o,
    output logic [2**SIZE-1:0]    busy_mask_o,
    output logic                  stall_req_o,
    output logic                  error_o
);

    localparam int NREGS = 2 ** SIZE;
    localparam int CW    = $clog2(MAX_STALL + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_STALL);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // ---------------------------------------------------------------------
    // Port-B FIFO
    // ---------------------------------------------------------------------
    logic      fifo_full;
    logic      fifo_empty;
    logic      fifo_push;
    logic      fifo_pop;
    wb_entry_t fifo_head;
    wb_entry_t b_entry;

    assign b_entry.rd   = b_register_i;
    assign b_entry.data = b_data_i;

    // Ready is held low during reset so nothing is handshaken while the
    // FIFO is being flushed.
    assign b_ready_o = !fifo_full && !reset;

    // Results destined for r0 complete the handshake but are dropped.
    assign fifo_push = b_valid_i && b_ready_o && (b_register_i != '0);

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (b_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    // ---------------------------------------------------------------------
    // Slot selection
    // ---------------------------------------------------------------------
    logic a_take;

    // A write to r0 is a no-op, so it leaves the slot for the FIFO.
    assign a_take   = a_valid_i && (a_register_i != '0);
    assign fifo_pop = !a_take && !fifo_empty;

    // ---------------------------------------------------------------------
    // Registered output stage
    // ---------------------------------------------------------------------
    logic      reg_write_q, reg_write_d;
    wb_entry_t wb_q, wb_d;

    always_comb begin
        reg_write_d = 1'b0;
        wb_d        = wb_q;
        if (a_take) begin
            reg_write_d = 1'b1;
            wb_d.rd     = a_register_i;
            wb_d.data   = a_data_i;
        end else if (fifo_pop) begin
            reg_write_d = 1'b1;
            wb_d        = fifo_head;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            wb_q        <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            wb_q        <= wb_d;
        end
    end

    assign reg_write_o      = reg_write_q;
    assign write_register_o = wb_q.rd;
    assign write_data_o     = wb_q.data;

    // ---------------------------------------------------------------------
    // Pending-write scoreboard
    // ---------------------------------------------------------------------
    logic [NREGS-1:0] busy_mask;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_busy
            if (gi == 0) begin : g_zero
                assign busy_mask[gi] = 1'b0;
            end else begin : g_bit
                logic bit_q, bit_d;
                logic set_hit;
                logic clr_hit;

                assign set_hit = fifo_push && (b_register_i == SIZE'(gi));
                assign clr_hit = fifo_pop && (fifo_head.rd == SIZE'(gi));

                // A new enqueue for r on the edge its previous entry pops
                // must leave r pending, so set has priority.
                always_comb begin
                    bit_d = bit_q;
                    if (set_hit) begin
                        bit_d = 1'b1;
                    end else if (clr_hit) begin
                        bit_d = 1'b0;
                    end
                end

                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        bit_q <= 1'b0;
                    end else begin
                        bit_q <= bit_d;
                    end
                end

                assign busy_mask[gi] = bit_q;
            end
        end
    endgenerate

    assign busy_mask_o = busy_mask;

    // ---------------------------------------------------------------------
    // Protocol error flag
    // ---------------------------------------------------------------------
    logic error_q, error_d;

    always_comb begin
        error_d = error_q;
        if (fifo_push && busy_mask[b_register_i]) begin
            error_d = 1'b1;
        end
        if (a_take && busy_mask[a_register_i]) begin
            error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;

    // ---------------------------------------------------------------------
    // Starvation counter and stall request
    // ---------------------------------------------------------------------
    // With a non-empty FIFO the only way to lose the slot is port A taking
    // it; every other case either pops or has nothing waiting, and both
    // clear the count.
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          stall_q, stall_d;

    always_comb begin
        stall_cnt_d = '0;
        if (!fifo_empty && a_take) begin
            stall_cnt_d = (stall_cnt_q == CNT_MAX) ? stall_cnt_q
                                                   : stall_cnt_q + CNT_ONE;
        end
        stall_d = (stall_cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            stall_q     <= stall_d;
        end
    end

    assign stall_req_o = stall_q;

endmodule : reg_file_wb_arbiter
